// File: rtl/gray_ptr_fifo.sv
// Single-clock FIFO whose read/write pointers are kept as Gray codes and exported for a later CDC wrapper.
// Latency: an element written on edge N is presented at the head after edge N; no same-cycle fall-through.
// Backpressure: elem_in_ready_o drops when full (or in reset), elem_out_valid_o drops when empty.
module gray_ptr_fifo #(
  parameter int ELEM_WIDTH = 8,
  parameter int FIFO_SIZE  = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [ELEM_WIDTH-1:0] elem_in_i,
  input  logic                  elem_in_valid_i,
  output logic                  elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0] elem_out_o,
  output logic                  elem_out_valid_o,
  input  logic                  elem_out_ready_i,
  output logic [FIFO_SIZE:0]    count_o,
  output logic [FIFO_SIZE:0]    wr_ptr_gray_o,
  output logic [FIFO_SIZE:0]    rd_ptr_gray_o
);

  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam int PW    = FIFO_SIZE + 1;

  // Reject depths the pointer arithmetic and storage were not sized for.
  generate
    if (FIFO_SIZE < 1 || FIFO_SIZE > 6) begin : g_bad_size
      $error("gray_ptr_fifo: FIFO_SIZE must be in 1..6");
    end
  endgenerate

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary -> Gray: adjacent binary values differ in exactly one Gray bit.
  function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [ELEM_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_gray;
  logic [PW-1:0]         rd_gray;
  logic [PW-1:0]         wr_bin;
  logic [PW-1:0]         rd_bin;
  logic [PW-1:0]         wr_bin_inc;
  logic [PW-1:0]         rd_bin_inc;
  logic                  full;
  logic                  empty;
  logic                  hsi;
  logic                  hso;

  // Decode the Gray pointers and derive occupancy flags from their binary form.
  always_comb begin
    wr_bin     = gray_to_bin(wr_gray);
    rd_bin     = gray_to_bin(rd_gray);
    wr_bin_inc = wr_bin + PW'(1);
    rd_bin_inc = rd_bin + PW'(1);
    empty      = (wr_bin == rd_bin);
    full       = (wr_bin[PW-1] != rd_bin[PW-1]) &&
                 (wr_bin[FIFO_SIZE-1:0] == rd_bin[FIFO_SIZE-1:0]);
  end

  // Flags depend only on registered pointers (and reset), never on the opposite-side handshake.
  assign elem_in_ready_o  = !arst_i && !full;
  assign elem_out_valid_o = !empty;
  assign hsi              = elem_in_valid_i && elem_in_ready_o;
  assign hso              = elem_out_valid_o && elem_out_ready_i;
  assign count_o          = wr_bin - rd_bin;
  assign elem_out_o       = mem[rd_bin[FIFO_SIZE-1:0]];
  assign wr_ptr_gray_o    = wr_gray;
  assign rd_ptr_gray_o    = rd_gray;

  // Storage: cleared on reset, written only on an accepted push.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (hsi) begin
      mem[wr_bin[FIFO_SIZE-1:0]] <= elem_in_i;
    end
  end

  // Write pointer advances one Gray step per accepted push.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_gray <= '0;
    end else if (hsi) begin
      wr_gray <= bin_to_gray(wr_bin_inc);
    end
  end

  // Read pointer advances one Gray step per accepted pop; storage is left as is.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_gray <= '0;
    end else if (hso) begin
      rd_gray <= bin_to_gray(rd_bin_inc);
    end
  end

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Directed bench for gray_ptr_fifo (ELEM_WIDTH=8, FIFO_SIZE=2).
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
// Expected values are hand-computed constants and a fixed Gray table.
module tb_gray_ptr_fifo;

  logic       clk_i;
  logic       arst_i;
  logic [7:0] elem_in_i;
  logic       elem_in_valid_i;
  logic       elem_in_ready_o;
  logic [7:0] elem_out_o;
  logic       elem_out_valid_o;
  logic       elem_out_ready_i;
  logic [2:0] count_o;
  logic [2:0] wr_ptr_gray_o;
  logic [2:0] rd_ptr_gray_o;

  int vectors;
  int miscompares;

  gray_ptr_fifo #(.ELEM_WIDTH(8), .FIFO_SIZE(2)) dut (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .elem_in_i        (elem_in_i),
    .elem_in_valid_i  (elem_in_valid_i),
    .elem_in_ready_o  (elem_in_ready_o),
    .elem_out_o       (elem_out_o),
    .elem_out_valid_o (elem_out_valid_o),
    .elem_out_ready_i (elem_out_ready_i),
    .count_o          (count_o),
    .wr_ptr_gray_o    (wr_ptr_gray_o),
    .rd_ptr_gray_o    (rd_ptr_gray_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [2:0] gtab [8];
    logic [2:0] prev_g;
    gtab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    vectors = 0;
    miscompares = 0;

    // Reset state
    arst_i = 1'b1;
    elem_in_i = 8'h00;
    elem_in_valid_i = 1'b0;
    elem_out_ready_i = 1'b0;
    #2;
    chk("rst_ready", elem_in_ready_o, 0);
    chk("rst_valid", elem_out_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_out", elem_out_o, 0);
    chk("rst_wg", wr_ptr_gray_o, 0);
    chk("rst_rg", rd_ptr_gray_o, 0);
    step();
    arst_i = 1'b0;
    #1;
    chk("idle_ready", elem_in_ready_o, 1);
    step();
    chk("idle_valid", elem_out_valid_o, 0);
    chk("idle_count", count_o, 0);
    chk("idle_wg", wr_ptr_gray_o, 0);
    chk("idle_rg", rd_ptr_gray_o, 0);

    // One push, then asynchronous reset mid-cycle
    elem_in_i = 8'hAA;
    elem_in_valid_i = 1'b1;
    step();
    elem_in_valid_i = 1'b0;
    chk("pre_rst_count", count_o, 1);
    chk("pre_rst_valid", elem_out_valid_o, 1);
    #2;
    arst_i = 1'b1;
    #1;
    chk("midrst_ready", elem_in_ready_o, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_valid", elem_out_valid_o, 0);
    #1;
    arst_i = 1'b0;
    #1;
    chk("midrel_ready", elem_in_ready_o, 1);
    step();

    // Fill with 0x11..0x44, then an overflow push that must be dropped
    elem_in_valid_i = 1'b1;
    elem_in_i = 8'h11; step(); chk("fill1_count", count_o, 1); chk("fill1_wg", wr_ptr_gray_o, 1);
    elem_in_i = 8'h22; step(); chk("fill2_count", count_o, 2); chk("fill2_wg", wr_ptr_gray_o, 3);
    elem_in_i = 8'h33; step(); chk("fill3_count", count_o, 3); chk("fill3_wg", wr_ptr_gray_o, 2);
    chk("fill3_ready", elem_in_ready_o, 1);
    elem_in_i = 8'h44; step(); chk("fill4_count", count_o, 4); chk("fill4_wg", wr_ptr_gray_o, 6);
    chk("full_ready", elem_in_ready_o, 0);
    chk("full_head", elem_out_o, 8'h11);
    elem_in_i = 8'h55; step();
    chk("ovf_count", count_o, 4);
    chk("ovf_wg", wr_ptr_gray_o, 6);
    chk("ovf_head", elem_out_o, 8'h11);
    elem_in_valid_i = 1'b0;

    // Drain all four in order
    elem_out_ready_i = 1'b1;
    step(); chk("pop1_head", elem_out_o, 8'h22); chk("pop1_count", count_o, 3); chk("pop1_rg", rd_ptr_gray_o, 1);
    chk("pop1_ready", elem_in_ready_o, 1);
    step(); chk("pop2_head", elem_out_o, 8'h33); chk("pop2_count", count_o, 2);
    step(); chk("pop3_head", elem_out_o, 8'h44); chk("pop3_count", count_o, 1);
    step(); chk("pop4_count", count_o, 0); chk("pop4_valid", elem_out_valid_o, 0);
    chk("pop4_rg", rd_ptr_gray_o, 6);
    elem_out_ready_i = 1'b0;

    // Prime two entries, then stream 20 cycles at a steady count of 2
    elem_in_valid_i = 1'b1;
    elem_in_i = 8'h60; step();
    elem_in_i = 8'h61; step();
    chk("prime_count", count_o, 2);
    chk("prime_wg", wr_ptr_gray_o, 5);
    elem_out_ready_i = 1'b1;
    prev_g = wr_ptr_gray_o;
    for (int i = 0; i < 20; i++) begin
      chk("stream_head", elem_out_o, 8'h60 + i);
      chk("stream_count", count_o, 2);
      elem_in_i = 8'h62 + 8'(i);
      step();
      chk("stream_wg", wr_ptr_gray_o, gtab[(7 + i) % 8]);
      chk("stream_rg", rd_ptr_gray_o, gtab[(5 + i) % 8]);
      chk("stream_onebit", $countones(prev_g ^ wr_ptr_gray_o), 1);
      prev_g = wr_ptr_gray_o;
    end
    elem_in_valid_i = 1'b0;
    chk("drain1_head", elem_out_o, 8'h74);
    step();
    chk("drain2_head", elem_out_o, 8'h75);
    step();
    chk("drain_valid", elem_out_valid_o, 0);
    chk("drain_count", count_o, 0);
    elem_out_ready_i = 1'b0;

    // Latency: valid must not rise until after the write edge
    elem_in_i = 8'h99;
    elem_in_valid_i = 1'b1;
    #1;
    chk("lat_same_cycle", elem_out_valid_o, 0);
    step();
    elem_in_valid_i = 1'b0;
    chk("lat_valid", elem_out_valid_o, 1);
    chk("lat_head", elem_out_o, 8'h99);
    chk("lat_count", count_o, 1);
    elem_out_ready_i = 1'b1;
    step();
    elem_out_ready_i = 1'b0;
    chk("lat_pop_count", count_o, 0);

    // Fill, then reset discards everything
    elem_in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      elem_in_i = 8'hA0 + 8'(i);
      step();
    end
    elem_in_valid_i = 1'b0;
    chk("refill_count", count_o, 4);
    #2;
    arst_i = 1'b1;
    #1;
    chk("r2_count", count_o, 0);
    chk("r2_valid", elem_out_valid_o, 0);
    chk("r2_out", elem_out_o, 0);
    chk("r2_wg", wr_ptr_gray_o, 0);
    chk("r2_rg", rd_ptr_gray_o, 0);
    chk("r2_ready", elem_in_ready_o, 0);
    step();
    arst_i = 1'b0;
    #1;

    // Post-reset push and pop returns the new data
    elem_in_i = 8'hBE;
    elem_in_valid_i = 1'b1;
    step();
    elem_in_valid_i = 1'b0;
    chk("post_head", elem_out_o, 8'hBE);
    chk("post_valid", elem_out_valid_o, 1);
    elem_out_ready_i = 1'b1;
    step();
    elem_out_ready_i = 1'b0;
    chk("post_count", count_o, 0);
    chk("post_empty", elem_out_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
